timer_int_ctrl: RTL and testbench

//  Downstream companion of the timer counter: compares the live count with the compare value
//  (TCMP1:TCMP0), keeps the sticky interrupt status (TISR.int_st), gates it with the enable
//  (TIER.int_en) onto tim_int, and runs the debug-halt handshake (THCSR) that freezes the counter.

---
 rtl/timer_int_ctrl.sv | 130 +++++++++++++
 tb/tb_timer_int_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_int_ctrl.sv
// timer_int_ctrl
//   Sits between the timer counter and the register block. Compares the live
//   count with the compare value, keeps the sticky interrupt status, gates it
//   with the enable onto tim_int, and runs the debug-halt handshake that
//   freezes the counter. All register storage lives upstream; this block only
//   holds the status bit, the match history and the halt state.
//
// Parameters
//   CNT_W     width of count and compare values
//   CMP_PIPE  0: match decided on current cnt_val, 1: one extra register stage
//
// Ports
//   sys_clk      in   system clock, rising edge
//   sys_rst_n    in   synchronous reset, active low
//   cnt_val      in   current counter value
//   cmp_val      in   compare value
//   int_en       in   interrupt enable
//   tisr_wr      in   one-cycle pulse, bus write to status register accepted
//   tisr_wdata0  in   bit0 of that write (write-1-to-clear)
//   halt_req     in   halt request from control register
//   dbg_mode     in   system debug mode
//   int_st       out  sticky compare status
//   tim_int      out  interrupt to system, int_st & int_en
//   halt_ack     out  halt acknowledge readback
//   cnt_halt     out  tells the counter to hold its count

module timer_int_ctrl #(
  parameter int CNT_W    = 64,
  parameter int CMP_PIPE = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             int_en,
  input  logic             tisr_wr,
  input  logic             tisr_wdata0,
  input  logic             halt_req,
  input  logic             dbg_mode,
  output logic             int_st,
  output logic             tim_int,
  output logic             halt_ack,
  output logic             cnt_halt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_t;

  halt_state_t state, state_next;

  logic match;
  logic match_use;
  logic match_d;
  logic set_ev;

  assign match = (cnt_val == cmp_val);

  // Optional register stage on the raw comparison, for timing closure on
  // wide counters. Everything downstream sees match_use.
  generate
    if (CMP_PIPE != 0) begin : g_cmp_pipe
      logic match_q;

      always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
          match_q <= 1'b0;
        end else begin
          match_q <= match;
        end
      end

      assign match_use = match_q;
    end else begin : g_cmp_direct
      assign match_use = match;
    end
  endgenerate

  // Status is set on the rising edge of the match only, so a counter frozen on
  // the compare value does not re-raise the status after software clears it.
  assign set_ev = match_use & ~match_d;

  // Set has priority over a simultaneous write-1-to-clear so no event is lost.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      match_d <= 1'b0;
      int_st  <= 1'b0;
    end else begin
      match_d <= match_use;
      if (set_ev) begin
        int_st <= 1'b1;
      end else if (tisr_wr && tisr_wdata0) begin
        int_st <= 1'b0;
      end
    end
  end

  assign tim_int = int_st & int_en;

  // Halt handshake state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Halting needs both the request and debug mode; dropping either releases.
  always_comb begin
    state_next = state;
    case (state)
      RUN:    if (halt_req && dbg_mode) state_next = HALTED;
      HALTED: if (!halt_req || !dbg_mode) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Handshake outputs decoded purely from the registered state.
  always_comb begin
    halt_ack = 1'b0;
    cnt_halt = 1'b0;
    if (state == HALTED) begin
      halt_ack = 1'b1;
      cnt_halt = 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_int_ctrl.sv
// tb_timer_int_ctrl
//   Drives two instances (direct compare and pipelined compare) from the same
//   stimulus. Each driven cycle produces expected outputs from a behavioural
//   model that reasons about "rising edge of equality seen L cycles late" and
//   "halted while request and debug were both high last cycle". Expectations
//   are queued; a monitor pops one per clock and compares.

module tb_timer_int_ctrl;

  localparam int CNT_W = 64;

  typedef struct {
    logic int_st;
    logic tim_int;
    logic halt_ack;
    logic cnt_halt;
  } exp_t;

  logic             sys_clk;
  logic             sys_rst_n;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cmp_val;
  logic             int_en;
  logic             tisr_wr;
  logic             tisr_wdata0;
  logic             halt_req;
  logic             dbg_mode;

  logic int_st0, tim_int0, halt_ack0, cnt_halt0;
  logic int_st1, tim_int1, halt_ack1, cnt_halt1;

  int compared   = 0;
  int mismatched = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Model state: equality history (one and two cycles back), status per
  // latency variant, and the halt flag.
  bit eq_prev1, eq_prev2;
  bit st_model [2];
  bit halted_model;

  timer_int_ctrl #(.CNT_W(CNT_W), .CMP_PIPE(0)) dut0 (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cnt_val     (cnt_val),
    .cmp_val     (cmp_val),
    .int_en      (int_en),
    .tisr_wr     (tisr_wr),
    .tisr_wdata0 (tisr_wdata0),
    .halt_req    (halt_req),
    .dbg_mode    (dbg_mode),
    .int_st      (int_st0),
    .tim_int     (tim_int0),
    .halt_ack    (halt_ack0),
    .cnt_halt    (cnt_halt0)
  );

  timer_int_ctrl #(.CNT_W(CNT_W), .CMP_PIPE(1)) dut1 (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cnt_val     (cnt_val),
    .cmp_val     (cmp_val),
    .int_en      (int_en),
    .tisr_wr     (tisr_wr),
    .tisr_wdata0 (tisr_wdata0),
    .halt_req    (halt_req),
    .dbg_mode    (dbg_mode),
    .int_st      (int_st1),
    .tim_int     (tim_int1),
    .halt_ack    (halt_ack1),
    .cnt_halt    (cnt_halt1)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs at the falling edge and queues what the
  // outputs must look like after the following rising edge.
  task automatic applyStimulus(input logic rst_n, input logic [CNT_W-1:0] cnt,
                               input logic [CNT_W-1:0] cmp, input logic en,
                               input logic wr, input logic wd,
                               input logic hreq, input logic dbg);
    bit eq;
    bit seen [3];
    bit set_now;
    exp_t e;
    @(negedge sys_clk);
    sys_rst_n   = rst_n;
    cnt_val     = cnt;
    cmp_val     = cmp;
    int_en      = en;
    tisr_wr     = wr;
    tisr_wdata0 = wd;
    halt_req    = hreq;
    dbg_mode    = dbg;

    eq = (cnt == cmp);
    if (!rst_n) begin
      eq_prev1     = 1'b0;
      eq_prev2     = 1'b0;
      st_model[0]  = 1'b0;
      st_model[1]  = 1'b0;
      halted_model = 1'b0;
    end else begin
      seen[0] = eq;
      seen[1] = eq_prev1;
      seen[2] = eq_prev2;
      for (int lat = 0; lat < 2; lat++) begin
        set_now = seen[lat] && !seen[lat+1];
        if (set_now) st_model[lat] = 1'b1;
        else if (wr && wd) st_model[lat] = 1'b0;
      end
      eq_prev2     = eq_prev1;
      eq_prev1     = eq;
      halted_model = hreq && dbg;
    end

    e.halt_ack = halted_model;
    e.cnt_halt = halted_model;
    e.int_st   = st_model[0];
    e.tim_int  = st_model[0] && en;
    exp_q0.push_back(e);
    e.int_st   = st_model[1];
    e.tim_int  = st_model[1] && en;
    exp_q1.push_back(e);
  endtask

  // Monitor: one expectation per instance per clock, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        checkOutput("p0_int_st",   int_st0,   e.int_st);
        checkOutput("p0_tim_int",  tim_int0,  e.tim_int);
        checkOutput("p0_halt_ack", halt_ack0, e.halt_ack);
        checkOutput("p0_cnt_halt", cnt_halt0, e.cnt_halt);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        checkOutput("p1_int_st",   int_st1,   e.int_st);
        checkOutput("p1_tim_int",  tim_int1,  e.tim_int);
        checkOutput("p1_halt_ack", halt_ack1, e.halt_ack);
        checkOutput("p1_cnt_halt", cnt_halt1, e.cnt_halt);
      end
    end
  end

  initial begin
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cmp_r;
    logic [CNT_W-1:0] all_ones;
    all_ones = '1;

    sys_rst_n = 1'b0; cnt_val = '0; cmp_val = '0; int_en = 1'b0;
    tisr_wr = 1'b0; tisr_wdata0 = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 64'd0, 64'd5, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 64'd0, 64'd5, 0, 0, 0, 0, 0);

    $display("[TB] count up to compare value 5, interrupt disabled");
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 64'(i), 64'd5, 0, 0, 0, 0, 0);

    $display("[TB] enable interrupt, then write-1-to-clear");
    applyStimulus(1'b1, 64'd9, 64'd5, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 64'd10, 64'd5, 1, 1, 1, 0, 0);
    applyStimulus(1'b1, 64'd11, 64'd5, 1, 0, 0, 0, 0);

    $display("[TB] clear coinciding with set, and write of zero");
    for (int i = 12; i < 20; i++)
      applyStimulus(1'b1, 64'(i), 64'd15, 1, (i == 15 || i == 16), 1, 0, 0);
    applyStimulus(1'b1, 64'd20, 64'd15, 1, 1, 0, 0, 0);
    applyStimulus(1'b1, 64'd21, 64'd15, 1, 1, 0, 0, 0);

    $display("[TB] halt request without debug, then with debug, then release");
    applyStimulus(1'b1, 64'd22, 64'd99, 1, 1, 1, 1, 0);
    applyStimulus(1'b1, 64'd23, 64'd99, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 64'd24, 64'd99, 1, 0, 0, 1, 1);
    applyStimulus(1'b1, 64'd24, 64'd99, 1, 0, 0, 1, 1);
    applyStimulus(1'b1, 64'd24, 64'd99, 1, 0, 0, 0, 1);
    applyStimulus(1'b1, 64'd25, 64'd99, 1, 0, 0, 0, 1);

    $display("[TB] counter frozen on compare value 0x10, clear does not re-set");
    applyStimulus(1'b1, 64'h0f, 64'h10, 1, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 64'h10, 64'h10, 1, (i == 3), 1, 1, 1);
    applyStimulus(1'b1, 64'h10, 64'h10, 1, 0, 0, 0, 1);

    $display("[TB] compare value change creates equality");
    applyStimulus(1'b1, 64'h30, 64'h31, 1, 1, 1, 0, 0);
    applyStimulus(1'b1, 64'h30, 64'h30, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 64'h30, 64'h30, 1, 0, 0, 0, 0);

    $display("[TB] reset while status set and halted");
    applyStimulus(1'b1, 64'h30, 64'h30, 1, 0, 0, 1, 1);
    applyStimulus(1'b1, 64'h30, 64'h30, 1, 0, 0, 1, 1);
    applyStimulus(1'b0, 64'h30, 64'h30, 1, 0, 0, 1, 1);
    applyStimulus(1'b1, 64'h40, 64'h30, 1, 0, 0, 0, 0);

    $display("[TB] wrap through all-ones, compare against zero");
    applyStimulus(1'b1, all_ones - 64'd1, 64'd0, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, all_ones, 64'd0, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 64'd0, 64'd0, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 64'd1, 64'd0, 1, 0, 0, 0, 0);
    applyStimulus(1'b1, 64'd2, 64'd0, 1, 0, 0, 0, 0);

    $display("[TB] randomized phase");
    base = {$urandom, $urandom};
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) base = {$urandom, $urandom};
      cnt_r = base + 64'($urandom_range(0, 3));
      cmp_r = base + 64'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cmp_r[CNT_W-1] = ~cmp_r[CNT_W-1];
      applyStimulus(($urandom_range(0, 49) != 0), cnt_r, cmp_r,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0));
    end

    @(posedge sys_clk);
    @(posedge sys_clk);
    #2;
    checkOutput("queue0_drained", (exp_q0.size() == 0), 1'b1);
    checkOutput("queue1_drained", (exp_q1.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
